// File: rtl/wavetable_voice_scheduler.sv
// -----------------------------------------------------------------------------
// wavetable_voice_scheduler
//
// Shares one sine wavetable ROM among VOICES oscillator voices. Each voice has
// a phase accumulator and a phase increment. An accepted sample_tick starts a
// frame. During the frame the block sends one phase per clock to the ROM,
// voices 0..VOICES-1 in order, and advances each accumulator by its increment.
// Each ROM result comes back on the out_* port, tagged with its voice index.
//
// Optional feature (macro WAVETABLE_SCHEDULER_PHASE_RESET_EN):
//   Adds input phase_reset. At an edge where it is high, the phase of voice
//   inc_voice is cleared (note-on sync). This clear wins over that voice's
//   same-edge accumulate. The issue on that edge still sends the old phase to
//   the ROM.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   sample_tick  in   one-cycle frame start request
//   inc_wr       in   write strobe for a phase increment
//   inc_voice    in   voice addressed by inc_wr / phase_reset
//   inc_data     in   increment value to write
//   phase_reset  in   (macro only) clear phase of inc_voice
//   rom_phase    out  registered phase to the wavetable ROM
//   rom_q        in   ROM data, ROM_LATENCY edges after rom_phase
//   out_valid    out  out_voice/out_value valid this cycle
//   out_voice    out  voice index of out_value
//   out_value    out  registered amplitude for out_voice
//   busy         out  a frame is in progress
//   frame_done   out  high together with the last out_valid of a frame
//   overrun      out  one-cycle pulse after a rejected sample_tick
// -----------------------------------------------------------------------------

package wavetable_pkg;
  localparam int PHASE_INDEX_BITS = 10;
  localparam int AMPLITUDE_BITS   = 16;
  typedef logic        [PHASE_INDEX_BITS-1:0] phase_index_type;
  typedef logic signed [AMPLITUDE_BITS-1:0]   amplitude;
endpackage

module wavetable_voice_scheduler
  import wavetable_pkg::*;
#(
  parameter  int VOICES      = 8,
  parameter  int ROM_LATENCY = 2,
  localparam int VW          = $clog2(VOICES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sample_tick,
  input  logic            inc_wr,
  input  logic [VW-1:0]   inc_voice,
  input  phase_index_type inc_data,
`ifdef WAVETABLE_SCHEDULER_PHASE_RESET_EN
  input  logic            phase_reset,
`endif
  output phase_index_type rom_phase,
  input  amplitude        rom_q,
  output logic            out_valid,
  output logic [VW-1:0]   out_voice,
  output amplitude        out_value,
  output logic            busy,
  output logic            frame_done,
  output logic            overrun
);

  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e          state_q;
  logic [VW-1:0]   issue_voice_q;
  phase_index_type phase_q [VOICES];
  phase_index_type inc_q   [VOICES];

  // Tag pipeline that runs alongside the ROM. Stage 0 is loaded on the issue
  // edge, together with rom_phase.
  logic [ROM_LATENCY-1:0] pipe_vld_q;
  logic [VW-1:0]          pipe_idx_q [ROM_LATENCY];

  phase_index_type rom_phase_q;
  logic            out_valid_q;
  logic [VW-1:0]   out_voice_q;
  amplitude        out_value_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            overrun_q;

  logic            issuing;
  logic            phase_clr_d;
  phase_index_type phase_sum_d;
  logic            tail_vld;
  logic [VW-1:0]   tail_idx;

  assign issuing     = (state_q == ISSUE);
  assign phase_sum_d = phase_q[issue_voice_q] + inc_q[issue_voice_q];
  assign tail_vld    = pipe_vld_q[ROM_LATENCY-1];
  assign tail_idx    = pipe_idx_q[ROM_LATENCY-1];

`ifdef WAVETABLE_SCHEDULER_PHASE_RESET_EN
  assign phase_clr_d = phase_reset;
`else
  assign phase_clr_d = 1'b0;
`endif

  // Per-voice phase and increment storage.
  // NOTE: these arrays sit in the async reset on purpose. All phases and
  // increments must be zero after reset, so they cannot be a plain RAM
  // without reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        // A phase clear wins over the accumulate of the voice being issued.
        // Increment writes take effect from the next issue of that voice.
        if (phase_clr_d && inc_voice == VW'(v)) begin
          phase_q[v] <= '0;
        end else if (issuing && issue_voice_q == VW'(v)) begin
          phase_q[v] <= phase_sum_d;
        end
        if (inc_wr && inc_voice == VW'(v)) begin
          inc_q[v] <= inc_data;
        end
      end
    end
  end

  // Frame FSM, tag pipeline and registered outputs.
  // NOTE: every register here uses non-blocking assignment. Then each
  // right-hand side reads the value from before the edge, which the
  // shift-register and issue logic depend on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      issue_voice_q <= '0;
      pipe_vld_q    <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_idx_q[i] <= '0;
      end
      rom_phase_q   <= '0;
      out_valid_q   <= 1'b0;
      out_voice_q   <= '0;
      out_value_q   <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      overrun_q <= sample_tick && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            state_q       <= ISSUE;
            issue_voice_q <= '0;
            busy_q        <= 1'b1;
          end
        end
        ISSUE: begin
          rom_phase_q <= phase_q[issue_voice_q];
          if (issue_voice_q == LAST_VOICE) begin
            state_q <= DRAIN;
          end else begin
            issue_voice_q <= issue_voice_q + VW'(1);
          end
        end
        DRAIN: begin
          // Stay until the cycle that shows the last output is over, so that
          // busy covers that cycle too.
          if (frame_done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      pipe_vld_q[0] <= issuing;
      pipe_idx_q[0] <= issue_voice_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end

      out_valid_q  <= tail_vld;
      frame_done_q <= tail_vld && (tail_idx == LAST_VOICE);
      if (tail_vld) begin
        out_voice_q <= tail_idx;
        out_value_q <= rom_q;
      end
    end
  end

  assign rom_phase  = rom_phase_q;
  assign out_valid  = out_valid_q;
  assign out_voice  = out_voice_q;
  assign out_value  = out_value_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wavetable_voice_scheduler
//
// The bench runs directed scenarios and then random traffic against a
// frame-level reference model. When the model issues a voice, it pushes the
// expected output into a queue. A monitor on the falling edge pops and compares
// each time out_valid is seen. The monitor also checks busy, overrun and
// rom_phase every cycle. The ROM is modelled as an identity table. rom_phase
// counts as the first of its ROM_LATENCY registers.
// -----------------------------------------------------------------------------

module tb_wavetable_voice_scheduler;
  import wavetable_pkg::*;

  localparam int V  = 4;
  localparam int L  = 2;
  localparam int VW = $clog2(V);
  localparam int PB = PHASE_INDEX_BITS;
  localparam int AB = AMPLITUDE_BITS;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            sample_tick = 1'b0;
  logic            inc_wr = 1'b0;
  logic [VW-1:0]   inc_voice = '0;
  phase_index_type inc_data = '0;
  logic            prst = 1'b0;
  phase_index_type rom_phase;
  amplitude        rom_q;
  logic            out_valid;
  logic [VW-1:0]   out_voice;
  amplitude        out_value;
  logic            busy;
  logic            frame_done;
  logic            overrun;

  wavetable_voice_scheduler #(.VOICES(V), .ROM_LATENCY(L)) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .inc_wr      (inc_wr),
    .inc_voice   (inc_voice),
    .inc_data    (inc_data),
`ifdef WAVETABLE_SCHEDULER_PHASE_RESET_EN
    .phase_reset (prst),
`endif
    .rom_phase   (rom_phase),
    .rom_q       (rom_q),
    .out_valid   (out_valid),
    .out_voice   (out_voice),
    .out_value   (out_value),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Identity wavetable with one register after rom_phase (L = 2).
  phase_index_type rom_r = '0;
  always @(posedge clock) rom_r <= rom_phase;
  assign rom_q = amplitude'({{(AB-PB){1'b0}}, rom_r});

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [VW-1:0] voice;
    amplitude      value;
    bit            last;
  } exp_t;

  exp_t            exp_q[$];
  phase_index_type ph_m [V];
  phase_index_type inc_m [V];
  phase_index_type rom_phase_m;
  int              cyc = 0;
  bit              acc_valid = 0;
  int              acc_edge = 0;
  bit              ovr_m = 0;
  bit              run_mon = 0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic void model_clear();
    for (int v = 0; v < V; v++) begin
      ph_m[v]  = '0;
      inc_m[v] = '0;
    end
    rom_phase_m = '0;
    exp_q.delete();
    acc_valid = 0;
    ovr_m     = 0;
  endfunction

  // Applies one rising edge to the model. Uses the inputs sampled at that edge.
  function automatic void model_edge();
    int              v;
    bit              iss;
    phase_index_type nxt;
    cyc++;
    iss = 0;
    v   = 0;
    // A frame accepted at edge A issues voice v at edge A+1+v.
    if (acc_valid && cyc > acc_edge && cyc <= acc_edge + V) begin
      iss = 1;
      v   = cyc - acc_edge - 1;
      rom_phase_m = ph_m[v];
      exp_q.push_back('{due: cyc + L, voice: 2'(v),
                        value: amplitude'({{(AB-PB){1'b0}}, ph_m[v]}),
                        last: (v == V - 1)});
    end
    nxt = ph_m[v] + inc_m[v];
    if (iss) ph_m[v] = nxt;
    if (prst) ph_m[inc_voice] = '0;
    if (inc_wr) inc_m[inc_voice] = inc_data;
    ovr_m = 0;
    if (sample_tick) begin
      // The block is idle again from acc_edge+V+L+1, so a tick is accepted
      // from the edge after that.
      if (!acc_valid || cyc >= acc_edge + V + L + 2) begin
        acc_valid = 1;
        acc_edge  = cyc;
      end else begin
        ovr_m = 1;
      end
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (run_mon && !reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out edge", 32'(cyc), 32'(e.due));
          check("out_voice", 32'(out_voice), 32'(e.voice));
          check("out_value", 32'(out_value), 32'(e.value));
          check("frame_done", 32'(frame_done), 32'(e.last));
        end
      end else begin
        check("frame_done idle", 32'(frame_done), 32'd0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          check("missing out_valid", 32'(out_valid), 32'd1);
          void'(exp_q.pop_front());
        end
      end
      check("busy", 32'(busy),
            32'(acc_valid && cyc >= acc_edge && cyc <= acc_edge + V + L));
      check("overrun", 32'(overrun), 32'(ovr_m));
      check("rom_phase", 32'(rom_phase), 32'(rom_phase_m));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cycle();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
  endtask

  task automatic write_inc(input int v, input phase_index_type d);
    inc_wr    = 1'b1;
    inc_voice = 2'(v);
    inc_data  = d;
    cycle();
    inc_wr    = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst rom_phase", 32'(rom_phase), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_voice", 32'(out_voice), 32'd0);
    check("rst out_value", 32'(out_value), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    @(negedge clock);
    do_reset();
    run_mon = 1;

    // Frame with all increments zero: four zero outputs.
    tick();
    idle(10);

    // Increments 1..4, then three frames spaced 10 clocks.
    for (int v = 0; v < V; v++) write_inc(v, phase_index_type'(v + 1));
    for (int f = 0; f < 3; f++) begin
      tick();
      idle(9);
    end

    // Largest increment on voice 0: the phase wraps silently.
    do_reset();
    write_inc(0, '1);
    for (int f = 0; f < 3; f++) begin
      tick();
      idle(9);
    end

    // Ticks at T+3 and T+7 are rejected.
    tick();
    idle(2);
    tick();
    idle(3);
    tick();
    idle(10);

    // Write voice 2's increment on the edge that issues voice 2.
    write_inc(2, phase_index_type'(3));
    tick();
    idle(2);
    write_inc(2, phase_index_type'(9));
    idle(8);
    tick();
    idle(9);
    // Reset in the middle of a frame, after edge T+5.
    tick();
    idle(5);
    do_reset();
    idle(12);

`ifdef WAVETABLE_SCHEDULER_PHASE_RESET_EN
    // Voice 1 reaches 0x40. It is then cleared on its own issue edge.
    write_inc(1, phase_index_type'(12'h40));
    tick();
    idle(9);
    write_inc(1, '0);
    tick();
    idle(1);
    prst      = 1'b1;
    inc_voice = 2'(1);
    cycle();
    prst      = 1'b0;
    idle(8);
    tick();
    idle(9);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      sample_tick = ($urandom_range(0, 5) == 0);
      inc_wr      = ($urandom_range(0, 3) == 0);
      inc_voice   = 2'($urandom_range(0, V - 1));
      inc_data    = phase_index_type'($urandom);
`ifdef WAVETABLE_SCHEDULER_PHASE_RESET_EN
      prst        = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end
    sample_tick = 1'b0;
    inc_wr      = 1'b0;
    prst        = 1'b0;
    idle(20);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
